servo_pulse_decoder: RTL and testbench
======================================

SERVO_PULSE_DECODER -- requirements
Module: servo_pulse_decoder

Interface
REQ-001 Parameter MIN_WIDTH, default 100000, is the minimum legal high time in CLK cycles (1.0 ms at 100 MHz).
REQ-002 Parameter MAX_WIDTH, default 200000, is the maximum legal high time in CLK cycles (2.0 ms at 100 MHz).
REQ-003 Parameter TIMEOUT, default 2500000, is the maximum number of CLK cycles without an edge (25 ms); TIMEOUT < 2^32 SHALL hold.
REQ-004 CLK  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-low.
REQ-006 EN  input  1  decoder enable; level-sensitive.
REQ-007 SERVO_IN  input  1  asynchronous servo PWM line under measurement.
REQ-008 PULSE_WIDTH  output  32  last measured high time in CLK cycles.
REQ-009 PERIOD  output  32  last measured rising-to-rising period in CLK cycles.
REQ-010 VALID  output  1  one-cycle strobe: new measurement with MIN_WIDTH <= PULSE_WIDTH <= MAX_WIDTH.
REQ-011 ERR  output  1  one-cycle strobe: new measurement with width out of range.
REQ-012 LOSS  output  1  level: the signal is lost (timeout).

Function
REQ-013 SERVO_IN SHALL pass through a 2-FF synchronizer, then a 1-FF edge detector; rise/fall SHALL be detected 3 CLK edges after the input transition.
REQ-014 States SHALL be IDLE, HIGH and LOW.
REQ-015 IDLE SHALL wait for a detected rising edge. It SHALL then clear both counters and go to HIGH, which discards any partial pulse present after reset or enable.
REQ-016 HIGH SHALL increment the width and period counters each cycle. A detected falling edge SHALL latch the width count and go to LOW.
REQ-017 LOW SHALL increment the period counter each cycle. A detected rising edge SHALL complete the measurement, restart both counters and return to HIGH.
REQ-018 On completion, PULSE_WIDTH and PERIOD SHALL update at the next clock edge. VALID or ERR (never both) SHALL assert for exactly that following cycle.
REQ-019 For an ideal input high N cycles and low M cycles, PULSE_WIDTH SHALL equal N and PERIOD SHALL equal N+M.
REQ-020 Width bounds SHALL be inclusive; a width equal to MIN_WIDTH or MAX_WIDTH SHALL give VALID.
REQ-021 In HIGH or LOW, if TIMEOUT cycles elapse since the last detected edge, LOSS SHALL set, the state SHALL go to IDLE, and no strobe SHALL be issued.
REQ-022 PULSE_WIDTH and PERIOD SHALL retain their last values on timeout.
REQ-023 LOSS SHALL clear on the next completed measurement, whether VALID or ERR.
REQ-024 EN low SHALL force IDLE within one cycle, suppress strobes and clear LOSS. Outputs PULSE_WIDTH and PERIOD SHALL hold their values.
REQ-025 If completion and timeout coincide, completion SHALL win.
REQ-026 Counters SHALL be 32-bit unsigned and SHALL never wrap, which the timeout guarantees.

Reset
REQ-027 RST low SHALL asynchronously force IDLE, clear counters and synchronizer flops, and set PULSE_WIDTH=0, PERIOD=0, VALID=0, ERR=0, LOSS=0.
REQ-028 Reset asserted mid-pulse SHALL produce no strobe. After release, the first measurement SHALL start at the next full rising edge.

Structure
REQ-029 State encodings and default MIN_WIDTH/MAX_WIDTH/TIMEOUT constants SHALL live in the shared project package/include, so servo_driver and this block share servo timing.
REQ-030 The synchronizer SHALL be a separate sub-module sync_2ff (1-bit, async active-low reset to 0); the remaining logic SHALL stay in one module.

Verification
Bench parameters: MIN_WIDTH=100, MAX_WIDTH=250, TIMEOUT=1000.
REQ-031 Reset, EN=1, high 150 / low 850 cycles, repeated -> second rising edge gives VALID one cycle, PULSE_WIDTH=150, PERIOD=1000, ERR=0.
REQ-032 High 100, then high 250, then high 251 (period 1000 each) -> VALID, VALID, then ERR with PULSE_WIDTH=251.
REQ-033 Line held low 1000+ cycles after a pulse -> LOSS=1, no strobe, values retained; next full pulse 150/850 -> VALID and LOSS=0.
REQ-034 Start with SERVO_IN already high at reset release -> no strobe until one complete rising-to-rising period; the first measurement ignores the partial pulse.
REQ-035 RST asserted mid-HIGH -> all outputs 0 immediately, no strobe; EN dropped mid-LOW -> no strobe, LOSS=0, values held.
REQ-036 Input edges asynchronous to CLK (random 0-9 ns skew) -> width within +/-1 of nominal and no metastability-induced double strobe.

Source files
------------

// File: rtl/servo_pulse_decoder_pkg.sv
// Shared servo timing constants and decoder state encoding.
// Also used by servo_driver so both blocks agree on pulse limits.
package servo_pulse_decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } dec_state_t;

   localparam int unsigned SERVO_MIN_WIDTH = 32'd100000;
   localparam int unsigned SERVO_MAX_WIDTH = 32'd200000;
   localparam int unsigned SERVO_TIMEOUT   = 32'd2500000;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/servo_pulse_decoder_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, resets to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/servo_pulse_decoder.sv
// Measures high time and rising-to-rising period of a servo PWM line,
// flagging in/out-of-range pulses and loss of signal.
module servo_pulse_decoder
   import servo_pulse_decoder_pkg::*;
#(
   parameter int unsigned MIN_WIDTH = SERVO_MIN_WIDTH,
   parameter int unsigned MAX_WIDTH = SERVO_MAX_WIDTH,
   parameter int unsigned TIMEOUT   = SERVO_TIMEOUT
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        EN,
   input  logic        SERVO_IN,
   output logic [31:0] PULSE_WIDTH,
   output logic [31:0] PERIOD,
   output logic        VALID,
   output logic        ERR,
   output logic        LOSS
);

   localparam logic [31:0] TO_LAST = TIMEOUT - 32'd1;

   logic       servo_sync;
   logic       servo_dly;
   logic [2:0] flush_sr;
   logic       rise;
   logic       fall;

   dec_state_t  state, state_n;
   logic [31:0] width_cnt, width_cnt_n;
   logic [31:0] period_cnt, period_cnt_n;
   logic [31:0] quiet_cnt, quiet_cnt_n;
   logic [31:0] width_hold, width_hold_n;
   logic [31:0] pulse_width_n, period_n;
   logic        valid_n, err_n, loss_n;

   sync_2ff u_sync (
      .clk   (CLK),
      .rst_n (RST),
      .d     (SERVO_IN),
      .q     (servo_sync)
   );

   // Edges are ignored until the synchronizer has flushed its reset value,
   // so a line already high at reset release is not taken as a rising edge.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         servo_dly <= 1'b0;
         flush_sr  <= '0;
      end else begin
         servo_dly <= servo_sync;
         flush_sr  <= {flush_sr[1:0], 1'b1};
      end
   end

   assign rise = flush_sr[2] &  servo_sync & ~servo_dly;
   assign fall = flush_sr[2] & ~servo_sync &  servo_dly;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state       <= ST_IDLE;
         width_cnt   <= '0;
         period_cnt  <= '0;
         quiet_cnt   <= '0;
         width_hold  <= '0;
         PULSE_WIDTH <= '0;
         PERIOD      <= '0;
         VALID       <= 1'b0;
         ERR         <= 1'b0;
         LOSS        <= 1'b0;
      end else begin
         state       <= state_n;
         width_cnt   <= width_cnt_n;
         period_cnt  <= period_cnt_n;
         quiet_cnt   <= quiet_cnt_n;
         width_hold  <= width_hold_n;
         PULSE_WIDTH <= pulse_width_n;
         PERIOD      <= period_n;
         VALID       <= valid_n;
         ERR         <= err_n;
         LOSS        <= loss_n;
      end
   end

   // Counts latched on an edge include the cycle in which the edge is seen,
   // giving exactly N and N+M for an ideal N-high/M-low input.
   always_comb begin
      state_n       = state;
      width_cnt_n   = sat_inc(width_cnt);
      period_cnt_n  = sat_inc(period_cnt);
      quiet_cnt_n   = sat_inc(quiet_cnt);
      width_hold_n  = width_hold;
      pulse_width_n = PULSE_WIDTH;
      period_n      = PERIOD;
      valid_n       = 1'b0;
      err_n         = 1'b0;
      loss_n        = LOSS;

      if (!EN) begin
         state_n      = ST_IDLE;
         width_cnt_n  = '0;
         period_cnt_n = '0;
         quiet_cnt_n  = '0;
         loss_n       = 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               width_cnt_n  = '0;
               period_cnt_n = '0;
               quiet_cnt_n  = '0;
               if (rise) state_n = ST_HIGH;
            end
            ST_HIGH: begin
               if (fall) begin
                  width_hold_n = sat_inc(width_cnt);
                  quiet_cnt_n  = '0;
                  state_n      = ST_LOW;
               end else if (quiet_cnt >= TO_LAST) begin
                  loss_n  = 1'b1;
                  state_n = ST_IDLE;
               end
            end
            ST_LOW: begin
               width_cnt_n = width_cnt;
               if (rise) begin
                  pulse_width_n = width_hold;
                  period_n      = sat_inc(period_cnt);
                  if (width_hold >= MIN_WIDTH && width_hold <= MAX_WIDTH)
                     valid_n = 1'b1;
                  else
                     err_n = 1'b1;
                  loss_n       = 1'b0;
                  width_cnt_n  = '0;
                  period_cnt_n = '0;
                  quiet_cnt_n  = '0;
                  state_n      = ST_HIGH;
               end else if (quiet_cnt >= TO_LAST) begin
                  loss_n  = 1'b1;
                  state_n = ST_IDLE;
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Directed self-checking bench for servo_pulse_decoder (MIN 100, MAX 250, TIMEOUT 1000).
module tb_servo_pulse_decoder;

   logic        CLK = 1'b0;
   logic        RST;
   logic        EN;
   logic        SERVO_IN;
   logic [31:0] PULSE_WIDTH;
   logic [31:0] PERIOD;
   logic        VALID;
   logic        ERR;
   logic        LOSS;

   int checks = 0;
   int errors = 0;
   int valid_count = 0;
   int err_count = 0;
   int both_count = 0;
   int vc0, ec0;

   servo_pulse_decoder #(
      .MIN_WIDTH (100),
      .MAX_WIDTH (250),
      .TIMEOUT   (1000)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .EN          (EN),
      .SERVO_IN    (SERVO_IN),
      .PULSE_WIDTH (PULSE_WIDTH),
      .PERIOD      (PERIOD),
      .VALID       (VALID),
      .ERR         (ERR),
      .LOSS        (LOSS)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (VALID) valid_count <= valid_count + 1;
      if (ERR) err_count <= err_count + 1;
      if (VALID && ERR) both_count <= both_count + 1;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: observed no finish, expected finish before 2 ms");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Hold SERVO_IN at level for n clock cycles; always returns 1 ns after a rising edge.
   task automatic drive(input logic level, input int n);
      SERVO_IN = level;
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Rising edge that completes a measurement; consumes 4 cycles of the new high time.
   task automatic expect_meas(input string tag, input logic exp_valid,
                              input logic [31:0] exp_pw, input logic [31:0] exp_per);
      drive(1'b1, 3);
      chk({tag, "_valid"}, {31'd0, VALID}, {31'd0, exp_valid});
      chk({tag, "_err"}, {31'd0, ERR}, {31'd0, ~exp_valid});
      chk({tag, "_pw"}, PULSE_WIDTH, exp_pw);
      chk({tag, "_per"}, PERIOD, exp_per);
      drive(1'b1, 1);
      chk({tag, "_strobe_off"}, {31'd0, VALID | ERR}, 32'd0);
   endtask

   initial begin
      int sk;
      RST = 1'b0;
      EN = 1'b0;
      SERVO_IN = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_pw", PULSE_WIDTH, 32'd0);
      chk("rst_per", PERIOD, 32'd0);
      chk("rst_valid", {31'd0, VALID}, 32'd0);
      chk("rst_err", {31'd0, ERR}, 32'd0);
      chk("rst_loss", {31'd0, LOSS}, 32'd0);
      RST = 1'b1;
      EN = 1'b1;
      drive(1'b0, 5);

      // Nominal 150/850 pulse train
      drive(1'b1, 150);
      drive(1'b0, 850);
      chk("first_no_strobe", valid_count + err_count, 32'd0);
      expect_meas("nom", 1'b1, 32'd150, 32'd1000);

      // Boundary widths
      drive(1'b1, 146);
      drive(1'b0, 850);
      expect_meas("nom2", 1'b1, 32'd150, 32'd1000);
      drive(1'b1, 96);
      drive(1'b0, 900);
      expect_meas("w100", 1'b1, 32'd100, 32'd1000);
      drive(1'b1, 246);
      drive(1'b0, 750);
      expect_meas("w250", 1'b1, 32'd250, 32'd1000);
      drive(1'b1, 247);
      drive(1'b0, 749);
      expect_meas("w251", 1'b0, 32'd251, 32'd1000);

      // Signal loss
      vc0 = valid_count;
      ec0 = err_count;
      drive(1'b1, 146);
      drive(1'b0, 1010);
      chk("loss_set", {31'd0, LOSS}, 32'd1);
      chk("loss_no_strobe", valid_count + err_count, vc0 + ec0);
      chk("loss_pw_kept", PULSE_WIDTH, 32'd251);
      chk("loss_per_kept", PERIOD, 32'd1000);
      drive(1'b1, 150);
      drive(1'b0, 850);
      chk("loss_held", {31'd0, LOSS}, 32'd1);
      expect_meas("recover", 1'b1, 32'd150, 32'd1000);
      chk("loss_cleared", {31'd0, LOSS}, 32'd0);

      // EN dropped mid-LOW
      drive(1'b1, 146);
      drive(1'b0, 300);
      vc0 = valid_count;
      ec0 = err_count;
      EN = 1'b0;
      drive(1'b0, 2);
      chk("en_loss", {31'd0, LOSS}, 32'd0);
      drive(1'b0, 548);
      drive(1'b1, 150);
      drive(1'b0, 850);
      chk("en_no_strobe", valid_count + err_count, vc0 + ec0);
      chk("en_pw_held", PULSE_WIDTH, 32'd150);
      chk("en_per_held", PERIOD, 32'd1000);
      EN = 1'b1;
      drive(1'b1, 150);
      drive(1'b0, 850);
      chk("en_restart_no_strobe", valid_count + err_count, vc0 + ec0);
      expect_meas("en_resume", 1'b1, 32'd150, 32'd1000);

      // Reset mid-HIGH, released with the line still high
      drive(1'b1, 50);
      vc0 = valid_count;
      ec0 = err_count;
      RST = 1'b0;
      #1;
      chk("mid_rst_pw", PULSE_WIDTH, 32'd0);
      chk("mid_rst_per", PERIOD, 32'd0);
      chk("mid_rst_strobe", {31'd0, VALID | ERR}, 32'd0);
      chk("mid_rst_loss", {31'd0, LOSS}, 32'd0);
      @(posedge CLK);
      #1;
      drive(1'b1, 3);
      RST = 1'b1;
      drive(1'b1, 100);
      drive(1'b0, 850);
      chk("partial_no_strobe", valid_count + err_count, vc0 + ec0);
      drive(1'b1, 150);
      drive(1'b0, 850);
      chk("partial_no_strobe2", valid_count + err_count, vc0 + ec0);
      expect_meas("after_rst", 1'b1, 32'd150, 32'd1000);

      // Edges skewed within the clock period
      drive(1'b1, 146);
      drive(1'b0, 850);
      vc0 = valid_count;
      ec0 = err_count;
      for (int i = 0; i < 4; i++) begin
         sk = $urandom_range(0, 8);
         #(sk);
         SERVO_IN = 1'b1;
         repeat (150) @(posedge CLK);
         #1;
         sk = $urandom_range(0, 8);
         #(sk);
         SERVO_IN = 1'b0;
         repeat (850) @(posedge CLK);
         #1;
      end
      drive(1'b1, 5);
      chk("skew_valid_count", valid_count - vc0, 32'd5);
      chk("skew_err_count", err_count - ec0, 32'd0);
      chk("skew_pw_range", {31'd0, (PULSE_WIDTH >= 149 && PULSE_WIDTH <= 151)}, 32'd1);
      chk("skew_per_range", {31'd0, (PERIOD >= 999 && PERIOD <= 1001)}, 32'd1);
      chk("never_both", both_count, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
